// File: rtl/pwr_rail_monitor.sv
// Rail enable sequencing and power-good supervision behind the power-init sequencer.
// Latency: rail_en follows step_req by 1 cycle; pg lags pgood_raw by 2 cycles (2+DEB_CYCLES with PGOOD_DEBOUNCE_EN).
// Backpressure: none; fault shutdown sheds rails highest-first, OFF_GAP apart, then holds until fault_clr with no requests.
// Optional build macro: PGOOD_DEBOUNCE_EN adds a per-rail DEB_CYCLES debounce on the synchronised power-good.
module pwr_rail_monitor #(
  parameter int N_RAIL     = 6,
  parameter int TMO_W      = 20,
  parameter int PG_TIMEOUT = 100000,
  parameter int OFF_GAP    = 1000,
  parameter int DEB_CYCLES = 16
) (
  input  logic              fsm_clk,
  input  logic              reset,
  input  logic [N_RAIL-1:0] step_req,
  input  logic [N_RAIL-1:0] pgood_raw,
  input  logic              fault_clr,
  output logic [N_RAIL-1:0] rail_en,
  output logic              rails_ok,
  output logic              pwr_fault,
  output logic [2:0]        fault_rail,
  output logic [1:0]        fault_type,
  output logic              seq_busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SHUTDN = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  localparam logic [1:0] FT_NONE    = 2'b00;
  localparam logic [1:0] FT_TIMEOUT = 2'b01;
  localparam logic [1:0] FT_DROPOUT = 2'b10;

  localparam int              GAP_W    = $clog2(OFF_GAP + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PG_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(OFF_GAP - 1);

  logic [N_RAIL-1:0] pg_meta, pg_sync, pg;
  logic [2:0]        state, state_nxt;
  logic [2:0]        cur_rail, cur_rail_nxt;
  logic [TMO_W-1:0]  timer, timer_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [N_RAIL-1:0] checked, checked_nxt, set_chk;
  logic [N_RAIL-1:0] shed_mask, shed_nxt;
  logic [N_RAIL-1:0] rail_en_nxt;
  logic [N_RAIL-1:0] new_rails, new_rest, dropped;
  logic              fault_nxt;
  logic [2:0]        frail_nxt;
  logic [1:0]        ftype_nxt;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] low_idx(input logic [N_RAIL-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_RAIL - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // One-hot of the highest set bit (0 when the vector is empty).
  function automatic logic [N_RAIL-1:0] top_bit(input logic [N_RAIL-1:0] v);
    logic [N_RAIL-1:0] r;
    r = '0;
    for (int i = 0; i < N_RAIL; i++) begin
      if (v[i]) r = N_RAIL'(1) << i;
    end
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous power-good pins.
  always_ff @(posedge fsm_clk) begin
    if (reset) begin
      pg_meta <= '0;
      pg_sync <= '0;
    end else begin
      pg_meta <= pgood_raw;
      pg_sync <= pg_meta;
    end
  end

`ifdef PGOOD_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0]  deb_cnt [N_RAIL];
  logic [N_RAIL-1:0] pg_qual;

  // Qualified pg flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge fsm_clk) begin
    if (reset) begin
      pg_qual <= '0;
      for (int i = 0; i < N_RAIL; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_RAIL; i++) begin
        if (pg_sync[i] != pg_qual[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            pg_qual[i] <= pg_sync[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign pg = pg_qual;
`else
  assign pg = pg_sync;
`endif

  assign new_rails = rail_en & ~checked;
  assign dropped   = checked & ~pg;

  // Next-state logic: ramp supervision, dropout detection, ordered shedding and clear gating.
  always_comb begin
    state_nxt    = state;
    cur_rail_nxt = cur_rail;
    timer_nxt    = timer;
    gap_nxt      = gap_cnt;
    shed_nxt     = shed_mask;
    set_chk      = '0;
    new_rest     = '0;
    fault_nxt    = pwr_fault;
    ftype_nxt    = fault_type;
    frail_nxt    = fault_rail;
    rail_en_nxt  = step_req & ~shed_mask;

    case (state)
      ST_IDLE: begin
        if (|new_rails) begin
          state_nxt    = ST_WAIT;
          cur_rail_nxt = low_idx(new_rails);
          timer_nxt    = '0;
        end
      end

      ST_WAIT: begin
        timer_nxt = (timer == TMO_LAST) ? timer : timer + TMO_W'(1);
        if (pg[cur_rail]) begin
          // pg wins over a coincident timeout.
          set_chk[cur_rail] = 1'b1;
          new_rest = new_rails & ~(N_RAIL'(1) << cur_rail);
          if (|new_rest) begin
            cur_rail_nxt = low_idx(new_rest);
            timer_nxt    = '0;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (!rail_en[cur_rail]) begin
          // Request withdrawn before power-good: not a fault.
          state_nxt = (rail_en == '0) ? ST_IDLE : ST_RUN;
        end else if (timer == TMO_LAST) begin
          state_nxt = ST_SHUTDN;
          fault_nxt = 1'b1;
          ftype_nxt = FT_TIMEOUT;
          frail_nxt = cur_rail;
          gap_nxt   = '0;
        end
      end

      ST_RUN: begin
        if (|dropped) begin
          state_nxt = ST_SHUTDN;
          fault_nxt = 1'b1;
          ftype_nxt = FT_DROPOUT;
          frail_nxt = low_idx(dropped);
          gap_nxt   = '0;
        end else if (|new_rails) begin
          state_nxt    = ST_WAIT;
          cur_rail_nxt = low_idx(new_rails);
          timer_nxt    = '0;
        end else if (rail_en == '0) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_SHUTDN: begin
        // Shed the highest enabled rail now, then one more every OFF_GAP cycles.
        if (gap_cnt == '0) begin
          shed_nxt = shed_mask | top_bit(rail_en & ~shed_mask);
          gap_nxt  = GAP_LAST;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
        rail_en_nxt = rail_en & ~shed_nxt;
        if (rail_en == '0) begin
          state_nxt   = ST_HOLD;
          rail_en_nxt = '0;
        end
      end

      ST_HOLD: begin
        rail_en_nxt = '0;
        // Clearing with requests still asserted would re-power uncontrolled.
        if (fault_clr && (step_req == '0)) begin
          state_nxt = ST_IDLE;
          fault_nxt = 1'b0;
          ftype_nxt = FT_NONE;
          frail_nxt = '0;
          shed_nxt  = '0;
          gap_nxt   = '0;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        rail_en_nxt = '0;
      end
    endcase

    checked_nxt = (checked | set_chk) & rail_en_nxt;
  end

  // State and output registers; reset drops every rail at once.
  always_ff @(posedge fsm_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_rail   <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      checked    <= '0;
      shed_mask  <= '0;
      rail_en    <= '0;
      rails_ok   <= 1'b0;
      pwr_fault  <= 1'b0;
      fault_type <= FT_NONE;
      fault_rail <= '0;
      seq_busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_rail   <= cur_rail_nxt;
      timer      <= timer_nxt;
      gap_cnt    <= gap_nxt;
      checked    <= checked_nxt;
      shed_mask  <= shed_nxt;
      rail_en    <= rail_en_nxt;
      rails_ok   <= (state_nxt == ST_RUN) && (&checked_nxt);
      pwr_fault  <= fault_nxt;
      fault_type <= ftype_nxt;
      fault_rail <= frail_nxt;
      seq_busy   <= (state_nxt == ST_WAIT) || (state_nxt == ST_SHUTDN);
    end
  end

endmodule

// File: tb/tb_pwr_rail_monitor.sv
// Scoreboard bench for pwr_rail_monitor: randomized ramps, timeouts, dropouts, clears, power-off, glitch and reset.
// Expected output changes (value + cycle) are queued by stimulus; a negedge monitor pops and compares them.
// Small timing parameters keep the run short; PGOOD_DEBOUNCE_EN shifts pg latency by DEB_CYCLES.
module tb_pwr_rail_monitor;
  localparam int N   = 6;
  localparam int PGT = 300;
  localparam int GAP = 40;
  localparam int DEB = 16;
`ifdef PGOOD_DEBOUNCE_EN
  localparam int DL = DEB;
`else
  localparam int DL = 0;
`endif

  logic         fsm_clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] step_req = '0;
  logic [N-1:0] pgood_raw = '0;
  logic         fault_clr = 1'b0;
  logic [N-1:0] rail_en;
  logic         rails_ok, pwr_fault, seq_busy;
  logic [2:0]   fault_rail;
  logic [1:0]   fault_type;

  pwr_rail_monitor #(
    .N_RAIL(N), .TMO_W(20), .PG_TIMEOUT(PGT), .OFF_GAP(GAP), .DEB_CYCLES(DEB)
  ) dut (
    .fsm_clk(fsm_clk), .reset(reset), .step_req(step_req), .pgood_raw(pgood_raw),
    .fault_clr(fault_clr), .rail_en(rail_en), .rails_ok(rails_ok), .pwr_fault(pwr_fault),
    .fault_rail(fault_rail), .fault_type(fault_type), .seq_busy(seq_busy)
  );

  always #5 fsm_clk = ~fsm_clk;

  int cyc = 0;
  always @(posedge fsm_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] val;
    int         at;
  } ev_t;

  // Queues: 0 = rail_en, 1 = rails_ok, 2 = {pwr_fault, fault_type, fault_rail}
  ev_t q_en[$];
  ev_t q_ok[$];
  ev_t q_flt[$];

  logic [5:0] exp_en = '0;

  task automatic push(int kind, logic [5:0] v, int c);
    ev_t e;
    e.val = v;
    e.at  = c;
    case (kind)
      0: q_en.push_back(e);
      1: q_ok.push_back(e);
      default: q_flt.push_back(e);
    endcase
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Report events whose cycle has passed without the output changing.
  task automatic mon_overdue(string nm, int kind);
    ev_t e;
    int  qs;
    qs = (kind == 0) ? q_en.size() : (kind == 1) ? q_ok.size() : q_flt.size();
    while (qs > 0) begin
      case (kind)
        0: e = q_en[0];
        1: e = q_ok[0];
        default: e = q_flt[0];
      endcase
      if (e.at >= cyc) break;
      checks++;
      errors++;
      $display("FAIL %s missed: no change by cycle %0d, required %0h at cycle %0d", nm, cyc, e.val, e.at);
      case (kind)
        0: void'(q_en.pop_front());
        1: void'(q_ok.pop_front());
        default: void'(q_flt.pop_front());
      endcase
      qs--;
    end
  endtask

  task automatic mon_cmp(string nm, int kind, logic [5:0] act);
    ev_t e;
    int  qs;
    qs = (kind == 0) ? q_en.size() : (kind == 1) ? q_ok.size() : q_flt.size();
    checks++;
    if (qs == 0) begin
      errors++;
      $display("FAIL %s unexpected change: got %0h at cycle %0d, required no change", nm, act, cyc);
      return;
    end
    case (kind)
      0: e = q_en.pop_front();
      1: e = q_ok.pop_front();
      default: e = q_flt.pop_front();
    endcase
    if (act !== e.val || cyc != e.at) begin
      errors++;
      $display("FAIL %s: got %0h at cycle %0d, required %0h at cycle %0d", nm, act, cyc, e.val, e.at);
    end
  endtask

  logic       mon_on = 1'b0;
  logic [5:0] p_en = '0;
  logic       p_ok = 1'b0;
  logic [5:0] p_flt = '0;

  always @(negedge fsm_clk) begin
    if (mon_on) begin
      mon_overdue("rail_en", 0);
      mon_overdue("rails_ok", 1);
      mon_overdue("fault", 2);
      if (rail_en !== p_en) begin
        mon_cmp("rail_en", 0, rail_en);
        p_en = rail_en;
      end
      if (rails_ok !== p_ok) begin
        mon_cmp("rails_ok", 1, {5'd0, rails_ok});
        p_ok = rails_ok;
      end
      if ({pwr_fault, fault_type, fault_rail} !== p_flt) begin
        mon_cmp("fault", 2, {pwr_fault, fault_type, fault_rail});
        p_flt = {pwr_fault, fault_type, fault_rail};
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge fsm_clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step(1);
  endtask

  // A request change shows on rail_en one cycle later.
  task automatic set_step(logic [5:0] v);
    step_req = v;
    push(0, v, cyc + 1);
    exp_en = v;
  endtask

  // Raise steps 1..6 in order; rail 'bad' never reports power-good and ends the ramp.
  task automatic ramp(int bad, output int r_last);
    logic [5:0] one;
    int         d;
    one = 6'd1;
    r_last = 0;
    for (int i = 0; i < N; i++) begin
      set_step(step_req | (one << i));
      r_last = cyc + 1;
      if (i == bad) return;
      d = $urandom_range(80, 20);
      step(d);
      pgood_raw[i] = 1'b1;
      // All rails good: seen 2 sync cycles (+debounce) later, registered on the next edge.
      if (i == N - 1) push(1, 6'd1, cyc + 3 + DL);
      step($urandom_range(90, 40));
    end
  endtask

  // Expected shedding: highest enabled first, next edge after fault entry, then every GAP cycles.
  task automatic expect_shed(int f, int n_drops);
    logic [5:0] cur;
    int         j;
    cur = exp_en;
    j = 0;
    for (int i = N - 1; i >= 0 && j < n_drops; i--) begin
      if (cur[i]) begin
        cur[i] = 1'b0;
        push(0, cur, f + 1 + j * GAP);
        j++;
      end
    end
    exp_en = cur;
  endtask

  task automatic clear_fault(logic [5:0] held);
    step_req = 6'h3F;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    step(5);
    check("clear ignored with requests", {pwr_fault, fault_type, fault_rail}, held);
    step_req = '0;
    pgood_raw = '0;
    step(3);
    fault_clr = 1'b1;
    push(2, 6'd0, cyc + 1);
    step(1);
    fault_clr = 1'b0;
    step(5);
    check("busy after clear", seq_busy, 0);
    exp_en = '0;
  endtask

  task automatic power_off();
    logic [5:0] one;
    one = 6'd1;
    for (int i = N - 1; i >= 0; i--) begin
      set_step(step_req & ~(one << i));
      if (i == N - 1) push(1, 6'd0, cyc + 1);
      step(10);
      pgood_raw[i] = 1'b0;
      step($urandom_range(50, 20));
    end
    step(10);
    check("busy after power-off", seq_busy, 0);
    check("rails_ok after power-off", rails_ok, 0);
  endtask

  task automatic timeout_case();
    int t, r, f;
    t = $urandom_range(5, 0);
    ramp(t, r);
    // Rail seen enabled at r, WAIT_PG from r+1 with timer 0, timer reaches PGT-1 at r+PGT.
    f = r + PGT + 1;
    push(2, {1'b1, 2'b01, 3'(t)}, f);
    expect_shed(f, t + 1);
    wait_until(f);
    check("busy in shutdown (timeout)", seq_busy, 1);
    wait_until(f + 2 + t * GAP);
    check("busy in hold (timeout)", seq_busy, 0);
    clear_fault({1'b1, 2'b01, 3'(t)});
  endtask

  task automatic dropout_case();
    int d, r, e, f;
    ramp(-1, r);
    step(20);
    d = $urandom_range(5, 0);
    e = cyc;
    pgood_raw[d] = 1'b0;
    f = e + 3 + DL;
    push(2, {1'b1, 2'b10, 3'(d)}, f);
    push(1, 6'd0, f);
    expect_shed(f, N);
    wait_until(f + 1 + (N - 1) * GAP);
    check("busy until last shed", seq_busy, 1);
    step(1);
    check("busy in hold (dropout)", seq_busy, 0);
    clear_fault({1'b1, 2'b10, 3'(d)});
  endtask

  task automatic glitch_reset_case();
    int r, e, f, frail, rr;
    ramp(-1, r);
    step(20);
    e = cyc;
    pgood_raw[3] = 1'b0;
`ifndef PGOOD_DEBOUNCE_EN
    f = e + 3;
    frail = 3;
    push(2, {1'b1, 2'b10, 3'(frail)}, f);
    push(1, 6'd0, f);
    expect_shed(f, 2);
`endif
    step(5);
    pgood_raw[3] = 1'b1;
`ifdef PGOOD_DEBOUNCE_EN
    step(40);
    check("glitch filtered", pwr_fault, 0);
    e = cyc;
    pgood_raw[2] = 1'b0;
    f = e + 3 + DEB;
    frail = 2;
    push(2, {1'b1, 2'b10, 3'(frail)}, f);
    push(1, 6'd0, f);
    expect_shed(f, 2);
`endif
    wait_until(f + 1 + GAP + 5);
    check("busy before reset", seq_busy, 1);
    rr = cyc;
    reset = 1'b1;
    push(0, 6'd0, rr + 1);
    push(2, 6'd0, rr + 1);
    step(1);
    check("busy after reset", seq_busy, 0);
    step(2);
    reset = 1'b0;
    pgood_raw = '0;
    step_req = '0;
    exp_en = '0;
    step(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    step(3);
    check("reset rail_en", rail_en, 0);
    check("reset rails_ok", rails_ok, 0);
    check("reset pwr_fault", pwr_fault, 0);
    check("reset fault_type", fault_type, 0);
    check("reset fault_rail", fault_rail, 0);
    check("reset seq_busy", seq_busy, 0);
    reset = 1'b0;
    mon_on = 1'b1;
    step(5);

    for (int it = 0; it < 2; it++) begin
      begin
        int r;
        ramp(-1, r);
      end
      step(30);
      check("no fault after ramp", pwr_fault, 0);
      power_off();
      step(20);
      timeout_case();
      step(20);
      dropout_case();
      step(20);
    end
    glitch_reset_case();

    step(10);
    check("rail_en events pending", q_en.size(), 0);
    check("rails_ok events pending", q_ok.size(), 0);
    check("fault events pending", q_flt.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
